mc_controller: RTL

Parametrised multicycle ARM-subset control unit with memory handshake and fault detection. It sits between the datapath and the unified instruction/data memory. It decodes Instr[31:12], sequences a Moore FSM, and holds the NZCV flags and the latched condition result. Compared with the previous controller it adds three things: memory wait states via mem_ready, a stall timeout, and illegal-instruction trapping into a sticky FAULT state.

---
 rtl/mc_controller.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control FSM with memory
// handshake, stall timeout and illegal-instruction trap.
module mc_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 fault,
  output logic [3:0]           state_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic             condex_q, condex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       sbit, rd15;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign sbit      = funct[0];
  assign rd15      = &Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  logic [2:0] alu_dp;
  logic       dp_legal, is_cmp, is_arith, is_logic;

  always_comb begin
    dp_legal = 1'b1;
    alu_dp   = 3'b000;
    case (cmd)
      4'b0100:          alu_dp = 3'b000;
      4'b0010, 4'b1010: alu_dp = 3'b001;
      4'b0000:          alu_dp = 3'b010;
      4'b1100:          alu_dp = 3'b011;
      4'b0001:          alu_dp = 3'b100;
      4'b1101:          alu_dp = 3'b101;
      default:          dp_legal = 1'b0;
    endcase
  end

  assign is_cmp   = (cmd == 4'b1010);
  assign is_arith = (cmd == 4'b0100) | (cmd == 4'b0010);
  assign is_logic = dp_legal & ~is_arith & ~is_cmp;

  logic illegal;
  assign illegal = (op == 2'b11)
                 | ((op == 2'b00) & ~dp_legal)
                 | ((op == 2'b01) & funct[5])
                 | ((op == 2'b10) & funct[4]);

  logic n, z, c, v, condex;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  logic is_wait, stall, tmo;
  assign is_wait = (state_q == FETCH) | (state_q == MEMRD)
                 | (state_q == MEMWR);
  assign stall   = is_wait & ~mem_ready;
  assign tmo     = (TIMEOUT != 0) && stall
                && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d   = (stall && !tmo) ? cnt_q + 1'b1 : '0;

  assign condex_d = (state_q == DECODE) ? condex : condex_q;

  // Only executed ALU ops touch the flags; logic ops keep C and V.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXECR || state_q == EXECI) && condex_q) begin
      if (is_cmp || (sbit && is_arith))
        flags_d = ALUFlags;
      else if (sbit && is_logic)
        flags_d[3:2] = ALUFlags[3:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
      cnt_q    <= cnt_d;
    end
  end

  logic       pc_w, mem_w, reg_w, ir_w, adr, flt;
  logic [1:0] sel_a, sel_b, sel_res;
  logic [2:0] alu3;

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    mem_w   = 1'b0;
    reg_w   = 1'b0;
    ir_w    = 1'b0;
    adr     = 1'b0;
    flt     = 1'b0;
    sel_a   = 2'b00;
    sel_b   = 2'b00;
    sel_res = 2'b00;
    alu3    = 3'b000;
    case (state_q)
      FETCH: begin
        sel_a   = 2'b01;
        sel_b   = 2'b10;
        sel_res = 2'b10;
        ir_w    = mem_ready;
        pc_w    = mem_ready;
        if (mem_ready)  state_d = DECODE;
        else if (tmo)   state_d = FAULT;
      end
      DECODE: begin
        sel_a   = 2'b01;
        sel_b   = 2'b10;
        sel_res = 2'b10;
        if (!condex)            state_d = FETCH;
        else if (illegal)       state_d = FAULT;
        else if (op == 2'b00)   state_d = funct[5] ? EXECI : EXECR;
        else if (op == 2'b01)   state_d = MEMADR;
        else                    state_d = BRANCH;
      end
      MEMADR: begin
        sel_b   = 2'b01;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr = 1'b1;
        if (mem_ready)  state_d = MEMWB;
        else if (tmo)   state_d = FAULT;
      end
      MEMWB: begin
        sel_res = 2'b01;
        reg_w   = 1'b1;
        pc_w    = rd15;
        state_d = FETCH;
      end
      MEMWR: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        if (mem_ready)  state_d = FETCH;
        else if (tmo)   state_d = FAULT;
      end
      EXECR, EXECI: begin
        sel_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu3    = alu_dp;
        state_d = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        pc_w    = rd15;
        state_d = FETCH;
      end
      BRANCH: begin
        sel_a   = 2'b10;
        sel_b   = 2'b01;
        sel_res = 2'b10;
        pc_w    = 1'b1;
        state_d = FETCH;
      end
      FAULT:   flt = 1'b1;
      default: state_d = FAULT;
    endcase
  end

  // Enables are gated by reset so nothing writes while it is held.
  assign PCWrite    = pc_w & reset;
  assign MemWrite   = mem_w & reset;
  assign RegWrite   = reg_w & reset;
  assign IRWrite    = ir_w & reset;
  assign AdrSrc     = adr;
  assign ALUSrcA    = sel_a;
  assign ALUSrcB    = sel_b;
  assign ResultSrc  = sel_res;
  assign ALUControl = ALUCTRL_W'(alu3);
  assign fault      = flt;
  assign state_o    = state_q;
  assign ImmSrc     = op;
  assign RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

endmodule
